pc_sequencer: RTL and testbench

//   Parametrised program-counter sequencer for the cellular-automaton processor core.
//   - Holds the PC and decodes the control-flow subset of the 16-bit ISA: JUMP, CALL, RET, UNL.
//   - Keeps a hardware return-address stack of configurable depth.
//   - Reports taken redirects to the fetch stage; halts on stack overflow/underflow.
//   - Sits between instruction fetch and the per-cell execute array; all PEs share its PC.

---
 rtl/pc_sequencer_if.sv | 28 ++
 rtl/pc_sequencer.sv | 141 ++++++++++++++
 tb/tb_pc_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the fetch/execute side and the PC sequencer.
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 12,
    parameter int STACK_DEPTH = 32
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                step_i;
    logic [15:0]         instr_i;
    logic                cond_i;
    logic                clear_i;
    logic [PC_WIDTH-1:0] pc_o;
    logic                taken_o;
    logic [DEPTH_W-1:0]  depth_o;
    logic                halted_o;
    logic                overflow_o;
    logic                underflow_o;

    modport master (
        output step_i, instr_i, cond_i, clear_i,
        input  pc_o, taken_o, depth_o, halted_o, overflow_o, underflow_o
    );

    modport slave (
        input  step_i, instr_i, cond_i, clear_i,
        output pc_o, taken_o, depth_o, halted_o, overflow_o, underflow_o
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: JUMP/CALL/RET/UNL decode with a hardware
// return-address stack shared by every PE in the cellular-automaton core.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | executing; one PC update per step_i
//   HALT  | stack overflow/underflow seen; frozen until clear_i
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 12,
    parameter int                  STACK_DEPTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input logic           clk,
    input logic           rst,
    pc_sequencer_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam int ADDR_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [3:0] OP_UNL  = 4'd1;
    localparam logic [3:0] OP_JUMP = 4'd12;
    localparam logic [3:0] OP_CALL = 4'd13;
    localparam logic [3:0] OP_RET  = 4'd14;

    typedef enum logic {RUN, HALT} state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt;
    logic [DEPTH_W-1:0]  depth, depth_nxt;
    logic                taken, taken_nxt;
    logic                ovf, ovf_nxt;
    logic                unf, unf_nxt;
    logic                push_en;

    logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];

    logic [3:0]          opcode;
    logic [PC_WIDTH-1:0] jump_addr;
    logic signed [7:0]   unl_off;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [ADDR_W-1:0]   push_idx;
    logic [ADDR_W-1:0]   pop_idx;
    logic                stack_full;
    logic                stack_empty;

    assign opcode      = bus.instr_i[15:12];
    assign jump_addr   = PC_WIDTH'(bus.instr_i[11:0]);
    assign unl_off     = bus.instr_i[7:0];
    assign pc_inc      = pc + PC_WIDTH'(1);
    assign push_idx    = ADDR_W'(depth);
    assign pop_idx     = ADDR_W'(depth - DEPTH_W'(1));
    assign stack_full  = (depth == DEPTH_W'(STACK_DEPTH));
    assign stack_empty = (depth == '0);

    // State and architectural registers; reset clears everything except the stack RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            pc    <= RESET_PC;
            depth <= '0;
            taken <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            depth <= depth_nxt;
            taken <= taken_nxt;
            ovf   <= ovf_nxt;
            unf   <= unf_nxt;
        end
    end

    // Next-state decode; clear_i takes priority so a concurrent step is dropped.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        depth_nxt = depth;
        taken_nxt = 1'b0;
        ovf_nxt   = ovf;
        unf_nxt   = unf;
        push_en   = 1'b0;
        if (bus.clear_i) begin
            state_nxt = RUN;
            depth_nxt = '0;
            ovf_nxt   = 1'b0;
            unf_nxt   = 1'b0;
        end else if (state == RUN && bus.step_i) begin
            case (opcode)
                OP_JUMP: begin
                    pc_nxt    = jump_addr;
                    taken_nxt = 1'b1;
                end
                OP_CALL: begin
                    if (stack_full) begin
                        ovf_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        push_en   = 1'b1;
                        depth_nxt = depth + DEPTH_W'(1);
                        pc_nxt    = jump_addr;
                        taken_nxt = 1'b1;
                    end
                end
                OP_RET: begin
                    if (stack_empty) begin
                        unf_nxt   = 1'b1;
                        state_nxt = HALT;
                    end else begin
                        depth_nxt = depth - DEPTH_W'(1);
                        pc_nxt    = stack_mem[pop_idx];
                        taken_nxt = 1'b1;
                    end
                end
                OP_UNL: begin
                    if (bus.cond_i) begin
                        pc_nxt = pc_inc;
                    end else begin
                        pc_nxt    = pc + PC_WIDTH'(unl_off);
                        taken_nxt = 1'b1;
                    end
                end
                default: pc_nxt = pc_inc;
            endcase
        end
    end

    // Return-address RAM; write suppressed while reset is held so no partial push lands.
    always_ff @(posedge clk) begin
        if (push_en && !rst) begin
            stack_mem[push_idx] <= pc_inc;
        end
    end

    assign bus.pc_o        = pc;
    assign bus.taken_o     = taken;
    assign bus.depth_o     = depth;
    assign bus.halted_o    = (state == HALT);
    assign bus.overflow_o  = ovf;
    assign bus.underflow_o = unf;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-deep stack and 12-bit PC.
module tb_pc_sequencer;
    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    pc_sequencer_if #(.PC_WIDTH(12), .STACK_DEPTH(4)) bus ();

    pc_sequencer #(.PC_WIDTH(12), .STACK_DEPTH(4), .RESET_PC(12'h000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_step(input logic [15:0] ins, input logic c);
        @(negedge clk);
        bus.step_i  = 1'b1;
        bus.instr_i = ins;
        bus.cond_i  = c;
        @(posedge clk);
        #1;
        bus.step_i  = 1'b0;
    endtask

    task automatic do_clear(input logic with_step, input logic [15:0] ins);
        @(negedge clk);
        bus.clear_i = 1'b1;
        bus.step_i  = with_step;
        bus.instr_i = ins;
        @(posedge clk);
        #1;
        bus.clear_i = 1'b0;
        bus.step_i  = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic [11:0] pc, input logic [2:0] d,
                             input logic tk, input logic h, input logic ov, input logic un);
        chk({tag, ".pc"},    32'(bus.pc_o),        32'(pc));
        chk({tag, ".depth"}, 32'(bus.depth_o),     32'(d));
        chk({tag, ".taken"}, 32'(bus.taken_o),     32'(tk));
        chk({tag, ".halt"},  32'(bus.halted_o),    32'(h));
        chk({tag, ".ovf"},   32'(bus.overflow_o),  32'(ov));
        chk({tag, ".unf"},   32'(bus.underflow_o), 32'(un));
    endtask

    initial begin
        rst         = 1'b1;
        bus.step_i  = 1'b0;
        bus.instr_i = 16'h0000;
        bus.cond_i  = 1'b0;
        bus.clear_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("reset", 12'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // JUMP, then taken drops with no step
        do_step(16'hC123, 1'b0);
        chk_state("jump", 12'h123, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk_state("jump_idle", 12'h123, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // CALL / RET pair
        do_step(16'hC010, 1'b0);
        chk("setpc.pc", 32'(bus.pc_o), 32'h010);
        do_step(16'hD200, 1'b0);
        chk_state("call", 12'h200, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        do_step(16'hE000, 1'b0);
        chk_state("ret", 12'h011, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Nested calls unwind in LIFO order
        do_step(16'hD0A0, 1'b0);
        do_step(16'hD0B0, 1'b0);
        chk_state("nest2", 12'h0B0, 3'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        do_step(16'hE000, 1'b0);
        chk("nest_ret1.pc", 32'(bus.pc_o), 32'h0A1);
        do_step(16'hE000, 1'b0);
        chk_state("nest_ret2", 12'h012, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Fill stack, fifth CALL overflows
        do_step(16'hD100, 1'b0);
        do_step(16'hD101, 1'b0);
        do_step(16'hD102, 1'b0);
        do_step(16'hD103, 1'b0);
        chk_state("full", 12'h103, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        do_step(16'hD104, 1'b0);
        chk_state("ovf", 12'h103, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        do_step(16'hC555, 1'b0);
        chk_state("ovf_hold", 12'h103, 3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
        do_clear(1'b1, 16'hC555);
        chk_state("clr_ovf", 12'h103, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // RET on empty stack underflows; halted until clear
        do_step(16'hE000, 1'b0);
        chk_state("unf", 12'h103, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_step(16'hC777, 1'b0);
        chk_state("unf_hold", 12'h103, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_clear(1'b0, 16'h0000);
        chk_state("clr_unf", 12'h103, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // UNL with negative offset wraps; cond set falls through
        do_step(16'hC005, 1'b0);
        do_step(16'h10F8, 1'b0);
        chk_state("unl_take", 12'hFFD, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_step(16'hC005, 1'b0);
        do_step(16'h10F8, 1'b1);
        chk_state("unl_fall", 12'h006, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_step(16'h1010, 1'b0);
        chk("unl_pos.pc", 32'(bus.pc_o), 32'h016);

        // PC wrap on sequential step and on return address
        do_step(16'hCFFF, 1'b0);
        do_step(16'h2000, 1'b0);
        chk_state("wrap_add", 12'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_step(16'hCFFF, 1'b0);
        do_step(16'hD050, 1'b0);
        do_step(16'hE000, 1'b0);
        chk_state("wrap_ret", 12'h000, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a CALL
        do_step(16'hD300, 1'b0);
        chk_state("pre_rst", 12'h300, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.step_i  = 1'b1;
        bus.instr_i = 16'hD400;
        #2;
        rst = 1'b1;
        #1;
        chk_state("rst_async", 12'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk_state("rst_held", 12'h000, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.step_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_step(16'hE000, 1'b0);
        chk_state("post_rst_ret", 12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
